// File: rtl/axi_user_arbiter.sv
// rtl/axi_user_arbiter.sv - two-requester round-robin arbiter issuing single AXI user transactions
module axi_user_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        M_ACLK,
  input  logic        M_ARESET,
  input  logic        R0_REQ,
  input  logic        R0_WE,
  input  logic [31:0] R0_ADDR,
  input  logic [31:0] R0_WDATA,
  input  logic [3:0]  R0_STRB,
  input  logic [3:0]  R0_BLEN,
  input  logic        R1_REQ,
  input  logic        R1_WE,
  input  logic [31:0] R1_ADDR,
  input  logic [31:0] R1_WDATA,
  input  logic [3:0]  R1_STRB,
  input  logic [3:0]  R1_BLEN,
  output logic        R0_GNT,
  output logic        R0_DONE,
  output logic        R0_ERR,
  output logic [31:0] R0_RDATA,
  output logic        R1_GNT,
  output logic        R1_DONE,
  output logic        R1_ERR,
  output logic [31:0] R1_RDATA,
  output logic        U_WVALID,
  output logic        U_RVALID,
  output logic [31:0] U_AWADDR,
  output logic [31:0] U_ARADDR,
  output logic [31:0] U_WDATA,
  output logic [3:0]  U_STRB,
  output logic [3:0]  U_BLEN,
  input  logic        X_WDONE,
  input  logic        X_RDONE,
  input  logic [31:0] X_RDATA,
  output logic        BUSY,
  output logic        OWNER
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic        we;

  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;
  logic [3:0]  sel_blen;
  logic [7:0]  cnt_next;
  logic        comp;
  logic        timeout_hit;

  // With both requesting, the one that did not win last time goes next.
  assign win       = (R0_REQ && R1_REQ) ? ~OWNER : R1_REQ;
  assign sel_we    = win ? R1_WE    : R0_WE;
  assign sel_addr  = win ? R1_ADDR  : R0_ADDR;
  assign sel_wdata = win ? R1_WDATA : R0_WDATA;
  assign sel_strb  = win ? R1_STRB  : R0_STRB;
  assign sel_blen  = win ? R1_BLEN  : R0_BLEN;

  // The counter value after this WAIT cycle decides the timeout, so the
  // limit is hit after exactly TIMEOUT WAIT cycles.
  assign cnt_next    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign comp        = we ? X_WDONE : X_RDONE;
  assign timeout_hit = (LIMIT != 8'd0) && (cnt_next == LIMIT);

  always_ff @(posedge M_ACLK) begin
    if (M_ARESET) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      we       <= 1'b0;
      OWNER    <= 1'b1;
      BUSY     <= 1'b0;
      R0_GNT   <= 1'b0;
      R1_GNT   <= 1'b0;
      R0_DONE  <= 1'b0;
      R1_DONE  <= 1'b0;
      R0_ERR   <= 1'b0;
      R1_ERR   <= 1'b0;
      R0_RDATA <= 32'd0;
      R1_RDATA <= 32'd0;
      U_WVALID <= 1'b0;
      U_RVALID <= 1'b0;
      U_AWADDR <= 32'd0;
      U_ARADDR <= 32'd0;
      U_WDATA  <= 32'd0;
      U_STRB   <= 4'd0;
      U_BLEN   <= 4'd0;
    end else begin
      R0_GNT   <= 1'b0;
      R1_GNT   <= 1'b0;
      R0_DONE  <= 1'b0;
      R1_DONE  <= 1'b0;
      R0_ERR   <= 1'b0;
      R1_ERR   <= 1'b0;
      U_WVALID <= 1'b0;
      U_RVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (R0_REQ || R1_REQ) begin
            state  <= ISSUE;
            BUSY   <= 1'b1;
            OWNER  <= win;
            cnt    <= 8'd0;
            we     <= sel_we;
            R0_GNT <= ~win;
            R1_GNT <= win;
            if (sel_we) begin
              U_WVALID <= 1'b1;
              U_AWADDR <= sel_addr;
              U_WDATA  <= sel_wdata;
              U_STRB   <= sel_strb;
            end else begin
              U_RVALID <= 1'b1;
              U_ARADDR <= sel_addr;
              U_BLEN   <= sel_blen;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          cnt <= cnt_next;
          if (comp || timeout_hit) begin
            state <= DONE;
            if (OWNER) begin
              R1_DONE <= 1'b1;
              R1_ERR  <= ~comp;
              if (comp && !we) R1_RDATA <= X_RDATA;
            end else begin
              R0_DONE <= 1'b1;
              R0_ERR  <= ~comp;
              if (comp && !we) R0_RDATA <= X_RDATA;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_user_arbiter.sv
// tb/tb_axi_user_arbiter.sv - table-driven and randomized bench for axi_user_arbiter
module tb_axi_user_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        R0_REQ, R0_WE, R1_REQ, R1_WE;
  logic [31:0] R0_ADDR, R0_WDATA, R1_ADDR, R1_WDATA;
  logic [3:0]  R0_STRB, R0_BLEN, R1_STRB, R1_BLEN;
  logic        R0_GNT, R0_DONE, R0_ERR, R1_GNT, R1_DONE, R1_ERR;
  logic [31:0] R0_RDATA, R1_RDATA;
  logic        U_WVALID, U_RVALID;
  logic [31:0] U_AWADDR, U_ARADDR, U_WDATA;
  logic [3:0]  U_STRB, U_BLEN;
  logic        X_WDONE, X_RDONE;
  logic [31:0] X_RDATA;
  logic        BUSY, OWNER;

  int n_vec  = 0;
  int n_miss = 0;

  logic        model_owner;
  logic [31:0] model_rdata [2];

  always #5 clk = ~clk;

  axi_user_arbiter #(.TIMEOUT(TO)) dut (
    .M_ACLK(clk), .M_ARESET(rst),
    .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
    .R0_STRB(R0_STRB), .R0_BLEN(R0_BLEN),
    .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
    .R1_STRB(R1_STRB), .R1_BLEN(R1_BLEN),
    .R0_GNT(R0_GNT), .R0_DONE(R0_DONE), .R0_ERR(R0_ERR), .R0_RDATA(R0_RDATA),
    .R1_GNT(R1_GNT), .R1_DONE(R1_DONE), .R1_ERR(R1_ERR), .R1_RDATA(R1_RDATA),
    .U_WVALID(U_WVALID), .U_RVALID(U_RVALID), .U_AWADDR(U_AWADDR),
    .U_ARADDR(U_ARADDR), .U_WDATA(U_WDATA), .U_STRB(U_STRB), .U_BLEN(U_BLEN),
    .X_WDONE(X_WDONE), .X_RDONE(X_RDONE), .X_RDATA(X_RDATA),
    .BUSY(BUSY), .OWNER(OWNER)
  );

  typedef struct {
    logic        r0, r1, we;
    logic [31:0] addr, wdata, xdata;
    logic [3:0]  strb, blen;
    int          delay;
    logic        noise;
    logic        exp_win, exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values;
    chk("rst_busy", BUSY, 0);
    chk("rst_owner", OWNER, 1);
    chk("rst_pulses", {R0_GNT, R1_GNT, R0_DONE, R1_DONE, R0_ERR, R1_ERR, U_WVALID, U_RVALID}, 0);
    chk("rst_awaddr", U_AWADDR, 0);
    chk("rst_araddr", U_ARADDR, 0);
    chk("rst_wdata", U_WDATA, 0);
    chk("rst_strb_blen", {U_STRB, U_BLEN}, 0);
    chk("rst_rdata0", R0_RDATA, 0);
    chk("rst_rdata1", R1_RDATA, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_values();
    rst = 1'b0;
    model_owner    = 1'b1;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
  endtask

  // One complete transaction: winner gets the given fields, the loser inverted ones.
  // delay = WAIT edge on which completion is sampled; 0 = never.
  task automatic run_txn(input vec_t v);
    int   lim;
    logic w;
    w = v.exp_win;
    R0_REQ = v.r0;
    R1_REQ = v.r1;
    R0_WE    = w ? ~v.we    : v.we;
    R0_ADDR  = w ? ~v.addr  : v.addr;
    R0_WDATA = w ? ~v.wdata : v.wdata;
    R0_STRB  = w ? ~v.strb  : v.strb;
    R0_BLEN  = w ? ~v.blen  : v.blen;
    R1_WE    = w ? v.we    : ~v.we;
    R1_ADDR  = w ? v.addr  : ~v.addr;
    R1_WDATA = w ? v.wdata : ~v.wdata;
    R1_STRB  = w ? v.strb  : ~v.strb;
    R1_BLEN  = w ? v.blen  : ~v.blen;
    tick();
    chk("gnt0", R0_GNT, !w);
    chk("gnt1", R1_GNT, w);
    chk("wvalid", U_WVALID, v.we);
    chk("rvalid", U_RVALID, !v.we);
    chk("owner", OWNER, w);
    chk("busy_issue", BUSY, 1);
    if (v.we) begin
      chk("awaddr", U_AWADDR, v.addr);
      chk("wdata", U_WDATA, v.wdata);
      chk("strb", U_STRB, v.strb);
    end else begin
      chk("araddr", U_ARADDR, v.addr);
      chk("blen", U_BLEN, v.blen);
    end
    R0_REQ  = 1'b0;
    R1_REQ  = 1'b0;
    X_WDONE = v.noise;
    X_RDONE = v.noise;
    tick();
    chk("issue_one_cycle", {R0_GNT, R1_GNT, U_WVALID, U_RVALID}, 0);
    lim = (v.delay != 0 && v.delay <= TO) ? v.delay : TO;
    for (int i = 1; i <= lim; i++) begin
      X_WDONE = v.we ? (i == v.delay) : (v.noise && $urandom_range(0, 1) == 1);
      X_RDONE = v.we ? (v.noise && $urandom_range(0, 1) == 1) : (i == v.delay);
      X_RDATA = (i == v.delay) ? v.xdata : $urandom;
      tick();
      if (i < lim) begin
        chk("no_early_done", {R0_DONE, R1_DONE}, 0);
        chk("busy_wait", BUSY, 1);
      end
    end
    X_WDONE = 1'b0;
    X_RDONE = 1'b0;
    if (!v.we && !v.exp_err) model_rdata[w] = v.xdata;
    model_owner = w;
    chk("done0", R0_DONE, !w);
    chk("done1", R1_DONE, w);
    chk("err0", R0_ERR, !w && v.exp_err);
    chk("err1", R1_ERR, w && v.exp_err);
    chk("rdata0", R0_RDATA, model_rdata[0]);
    chk("rdata1", R1_RDATA, model_rdata[1]);
    chk("busy_done", BUSY, 1);
    tick();
    chk("idle_busy", BUSY, 0);
    chk("done_one_cycle", {R0_DONE, R1_DONE, R0_ERR, R1_ERR}, 0);
  endtask

  initial begin
    vec_t v;
    //            r0    r1    we    addr          wdata         xdata         strb  blen  dly ns    win   err
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0,        4'h3, 4'h0, 2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'hCAFE_0001, 4'h0, 4'h2, 1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0,         32'h1234_5678, 4'h0, 4'h7, 4, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h2222_3333, 32'h0,        4'hC, 4'h0, 3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,        4'hF, 4'h0, 3, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 4'h0, 4'h4, 2, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'h5555_0000, 4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hBEEF_0008, 4'h0, 4'h8, 8, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h0000_0050, 32'h7777_7777, 32'h0,        4'h5, 4'h0, 9, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h0000_0060, 32'h0,         32'h9999_9999, 4'h0, 4'h3, 0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    {R0_REQ, R0_WE, R1_REQ, R1_WE, X_WDONE, X_RDONE} = '0;
    {R0_ADDR, R0_WDATA, R1_ADDR, R1_WDATA, X_RDATA} = '0;
    {R0_STRB, R0_BLEN, R1_STRB, R1_BLEN} = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.r0 = 1'($urandom_range(0, 1));
      v.r1 = 1'($urandom_range(0, 1));
      if (!v.r0 && !v.r1) v.r0 = 1'b1;
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.xdata = $urandom;
      v.strb  = 4'($urandom_range(0, 15));
      v.blen  = 4'($urandom_range(0, 15));
      v.delay = int'($urandom_range(0, TO + 2));
      v.noise = 1'($urandom_range(0, 1));
      v.exp_win = (v.r0 && v.r1) ? !model_owner : v.r1;
      v.exp_err = !(v.delay != 0 && v.delay <= TO);
      run_txn(v);
    end

    // Reset in the middle of a write's WAIT, then a late completion.
    R0_REQ = 1'b1; R0_WE = 1'b1; R0_ADDR = 32'h0000_0070;
    tick();
    chk("abort_gnt", R0_GNT, 1);
    R0_REQ = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_values();
    rst = 1'b0;
    model_owner    = 1'b1;
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
    X_WDONE = 1'b1;
    tick();
    X_WDONE = 1'b0;
    chk("abort_no_done", {R0_DONE, R1_DONE, R0_ERR, R1_ERR}, 0);
    chk("abort_busy", BUSY, 0);
    tick();
    chk("abort_no_done2", {R0_DONE, R1_DONE}, 0);
    chk_reset_values();

    v = tbl[0];
    run_txn(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_user_arbiter.md
AXI_USER_ARBITER -- requirements
Module: axi_user_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: WAIT-state cycle limit, 0..255; 0 disables timeout.
REQ-002 M_ACLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 M_ARESET  input  1  reset, synchronous and active-high.
REQ-004 R0_REQ / R1_REQ  input  1  level request from requester n; held until Rn_GNT.
REQ-005 R0_WE / R1_WE  input  1  1 = write, 0 = read.
REQ-006 R0_ADDR / R1_ADDR  input  32  transaction address.
REQ-007 R0_WDATA / R1_WDATA  input  32  write data.
REQ-008 R0_STRB / R1_STRB  input  4  write byte strobes.
REQ-009 R0_BLEN / R1_BLEN  input  4  read burst length.
REQ-010 R0_GNT / R1_GNT  output  1  one-cycle pulse; request accepted.
REQ-011 R0_DONE / R1_DONE  output  1  one-cycle pulse; transaction finished.
REQ-012 R0_ERR / R1_ERR  output  1  valid with Rn_DONE; 1 = timeout.
REQ-013 R0_RDATA / R1_RDATA  output  32  last read data returned to requester n.
REQ-014 U_WVALID, U_RVALID  output  1  one-cycle write/read launch to the AXI master.
REQ-015 U_AWADDR, U_ARADDR  output  32; U_WDATA  output  32; U_STRB  output  4; U_BLEN  output  4: latched transaction fields.
REQ-016 X_WDONE  input  1  write completion seen on the AXI W handshake.
REQ-017 X_RDONE  input  1  read completion seen on the AXI R handshake; X_RDATA  input  32  data valid with it.
REQ-018 BUSY  output  1  high in any state except IDLE; OWNER  output  1  index of the current/last granted requester.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-020 IDLE: at an edge with any Rn_REQ=1, the arbiter selects the winner, latches its WE/ADDR/WDATA/STRB/BLEN and moves to ISSUE.
REQ-021 Arbitration is round-robin: a single requester always wins; with both requesting, the one not equal to OWNER wins.
REQ-022 ISSUE lasts exactly one cycle: Rn_GNT=1 for the winner, U_WVALID=1 if WE else U_RVALID=1, OWNER=winner; next state WAIT.
REQ-023 U_AWADDR/U_WDATA/U_STRB (write) or U_ARADDR/U_BLEN (read) carry latched values from ISSUE and hold them until the next grant, including through IDLE.
REQ-024 WAIT: 8-bit counter cleared on ISSUE entry, increments each WAIT cycle, saturates at 255.
REQ-025 WAIT exits to DONE on X_WDONE (write) or X_RDONE (read); completion of the other type is ignored.
REQ-026 Completion pulses during ISSUE, DONE or IDLE are ignored.
REQ-027 With TIMEOUT!=0, WAIT exits to DONE with the error flag set once the counter equals TIMEOUT.
REQ-028 Completion and timeout on the same edge: completion wins, ERR=0.
REQ-029 Read completion captures X_RDATA into the owner's Rn_RDATA; writes and timeouts leave Rn_RDATA unchanged.
REQ-030 DONE lasts one cycle: owner's Rn_DONE=1, Rn_ERR=error flag; next state IDLE. The other requester's outputs stay 0.
REQ-031 Rn_REQ still high after Rn_DONE is a new request; minimum request-to-request spacing is ISSUE+WAIT(>=1)+DONE+IDLE.
REQ-032 Latency: REQ sampled at edge k gives GNT/U_xVALID in cycle k+1; completion sampled at edge m gives DONE in cycle m+1.

Reset
REQ-033 While M_ARESET=1 at an edge: state IDLE, OWNER=1 (R0 wins first tie), counter 0, all GNT/DONE/ERR/U_WVALID/U_RVALID 0, all address/data/strobe/BLEN/RDATA outputs 0, BUSY 0.
REQ-034 Reset during ISSUE/WAIT/DONE aborts the transaction; no Rn_DONE is issued for it, and a late completion after reset is ignored.

Verification
REQ-035 R0 write ADDR=0x10, WDATA=0xA5A5A5A5, STRB=0xF; X_WDONE 3 cycles after U_WVALID -> R0_GNT, U_WVALID one cycle, U_AWADDR=0x10; R0_DONE=1, R0_ERR=0, R0_RDATA unchanged.
REQ-036 R1 read ADDR=0x20, BLEN=4; X_RDONE with X_RDATA=0xDEADBEEF -> U_RVALID one cycle, U_ARADDR=0x20, U_BLEN=4; R1_RDATA=0xDEADBEEF, R1_DONE=1.
REQ-037 Both REQ held high through 4 transactions from reset -> grant order R0, R1, R0, R1.
REQ-038 TIMEOUT=8, no completion -> Rn_DONE=1, Rn_ERR=1 exactly 8 WAIT cycles after entry; X_RDONE on the limit edge -> ERR=0.
REQ-039 M_ARESET asserted mid-WAIT, then X_WDONE -> no DONE pulse, BUSY=0, all outputs at reset values.
REQ-040 X_WDONE during a read's WAIT, X_RDONE during ISSUE -> both ignored; FSM stays in WAIT until X_RDONE.
